// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the MEM stage (master) and
// the multi-cycle data-memory responder (slave).
interface dmem_responder_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] address;
   logic [31:0] w_data;
   logic [31:0] r_data;
   logic        stall;
   logic        resp_valid;
   logic        misaligned;

   // MemRead/MemWrite/address/w_data are held by the master while stall=1;
   // the access completes in the cycle where resp_valid=1.
   modport master (
      output MemRead, MemWrite, address, w_data,
      input  r_data, stall, resp_valid, misaligned
   );

   modport slave (
      input  MemRead, MemWrite, address, w_data,
      output r_data, stall, resp_valid, misaligned
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory with fixed LATENCY that stalls the pipeline per access.
// Optional macro DMEM_ALIGN_CHECK_EN enables sticky misaligned-address detection.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   dmem_responder_if.slave     bus,
   output logic [1:0]          dbg_state_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            op_rd_q, op_rd_d;
   logic            op_wr_q, op_wr_d;
   logic            bad_q, bad_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     r_data_q, r_data_d;
   logic            mis_q, mis_d;

   logic [31:0]     mem_q [DEPTH_WORDS];

   logic            req_c;
   logic            bad_req_c;
   logic            commit_c;
   logic            wr_en_c;
   logic            cur_rd_c, cur_wr_c, cur_bad_c;
   logic [AW-1:0]   cur_idx_c;
   logic [31:0]     cur_wdata_c;
   logic [31:0]     unused_addr_bits;

   assign req_c = bus.MemRead | bus.MemWrite;

`ifdef DMEM_ALIGN_CHECK_EN
   assign bad_req_c = (bus.address[1:0] != 2'b00);
`else
   assign bad_req_c = 1'b0;
`endif

   // Upper bits wrap modulo the array; low byte-offset bits only matter to the align check.
   assign unused_addr_bits = bus.address;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_rd_d  = op_rd_q;
      op_wr_d  = op_wr_q;
      bad_d    = bad_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      mis_d    = mis_q;
      case (state_q)
         IDLE: begin
            if (req_c) begin
               op_rd_d = bus.MemRead;
               op_wr_d = bus.MemWrite;
               bad_d   = bad_req_c;
               idx_d   = bus.address[AW+1:2];
               wdata_d = bus.w_data;
               cnt_d   = 4'(LATENCY);
               state_d = (LATENCY > 0) ? WAIT : DONE;
               if (bad_req_c) begin
                  mis_d = 1'b1;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // With zero latency the commit happens straight from IDLE, so the access
   // fields come from the live inputs rather than the latched copies.
   always_comb begin
      cur_rd_c    = op_rd_q;
      cur_wr_c    = op_wr_q;
      cur_bad_c   = bad_q;
      cur_idx_c   = idx_q;
      cur_wdata_c = wdata_q;
      if (state_q == IDLE) begin
         cur_rd_c    = bus.MemRead;
         cur_wr_c    = bus.MemWrite;
         cur_bad_c   = bad_req_c;
         cur_idx_c   = bus.address[AW+1:2];
         cur_wdata_c = bus.w_data;
      end
      commit_c = (state_d == DONE) && (state_q != DONE);
      wr_en_c  = commit_c && cur_wr_c && !cur_bad_c;
      r_data_d = r_data_q;
      if (commit_c && cur_rd_c) begin
         r_data_d = cur_bad_c ? 32'h0 : mem_q[cur_idx_c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         op_rd_q  <= 1'b0;
         op_wr_q  <= 1'b0;
         bad_q    <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= 32'h0;
         r_data_q <= 32'h0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_rd_q  <= op_rd_d;
         op_wr_q  <= op_wr_d;
         bad_q    <= bad_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         r_data_q <= r_data_d;
         mis_q    <= mis_d;
      end
   end

   // Storage is not reset; gating with rst_n makes a reset at the commit edge abort the write.
   always_ff @(posedge clk) begin
      if (wr_en_c && rst_n) begin
         mem_q[cur_idx_c] <= cur_wdata_c;
      end
   end

   assign bus.r_data     = r_data_q;
   assign bus.stall      = ((state_q == IDLE) && req_c) || (state_q == WAIT);
   assign bus.resp_valid = (state_q == DONE);
   assign bus.misaligned = mis_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 and one LATENCY=0 instance.
// Covers timing, read/write data, wrap, read+write, input drop, alignment and reset abort.
module tb_dmem_responder;

   logic clk;
   logic rst_n;
   logic [1:0] dbg2, dbg0;
   int n_checks;
   int n_errors;
   logic [31:0] exp_q[$];

   dmem_responder_if bus2 ();
   dmem_responder_if bus0 ();

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus2),
      .dbg_state_o (dbg2)
   );

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus0),
      .dbg_state_o (dbg0)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input bit use0, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (use0) begin
         bus0.MemRead = rd; bus0.MemWrite = wr; bus0.address = a; bus0.w_data = d;
      end else begin
         bus2.MemRead = rd; bus2.MemWrite = wr; bus2.address = a; bus2.w_data = d;
      end
   endtask

   task automatic do_access(input bit use0, input bit rd, input bit wr,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input bit hold, input string tag, output logic [31:0] rdata);
      int lat, stalls, cyc;
      bit got;
      lat = use0 ? 0 : 2;
      stalls = 0; cyc = 0; got = 1'b0; rdata = '0;
      @(posedge clk); #1;
      drive(use0, rd, wr, addr, wd);
      while (!got && cyc < 40) begin
         #1;
         cyc++;
         if (use0 ? bus0.stall : bus2.stall) stalls++;
         if (use0 ? bus0.resp_valid : bus2.resp_valid) begin
            got = 1'b1;
            rdata = use0 ? bus0.r_data : bus2.r_data;
         end else begin
            @(posedge clk); #1;
            if (!hold) drive(use0, 1'b0, 1'b0, 32'h0, 32'h0);
         end
      end
      drive(use0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_eq({tag, " resp seen"}, 32'(got), 32'd1);
      check_eq({tag, " stall cycles"}, stalls, lat + 1);
      check_eq({tag, " resp cycle"}, cyc, lat + 2);
   endtask

   task automatic write_acc(input bit use0, input logic [31:0] addr,
                            input logic [31:0] d, input string tag);
      logic [31:0] r;
      do_access(use0, 1'b0, 1'b1, addr, d, 1'b1, tag, r);
   endtask

   // scoreboard: expected read data queued at issue, popped at response
   task automatic read_chk(input bit use0, input logic [31:0] addr,
                           input logic [31:0] exp, input string tag);
      logic [31:0] r;
      exp_q.push_back(exp);
      do_access(use0, 1'b1, 1'b0, addr, 32'h0, 1'b1, tag, r);
      check_eq({tag, " r_data"}, r, exp_q.pop_front());
   endtask

   initial begin
      logic [31:0] r;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_eq("idle r_data", bus2.r_data, 32'h0);
         check_eq("idle resp_valid", 32'(bus2.resp_valid), 32'd0);
         check_eq("idle stall", 32'(bus2.stall), 32'd0);
         check_eq("idle misaligned", 32'(bus2.misaligned), 32'd0);
      end
      check_eq("idle state", 32'(dbg2), 32'd0);

      write_acc(1'b0, 32'h10, 32'hDEADBEEF, "wr 0x10");
      read_chk(1'b0, 32'h10, 32'hDEADBEEF, "rd 0x10");

      write_acc(1'b1, 32'h4, 32'h12345678, "lat0 wr 0x4");
      read_chk(1'b1, 32'h4, 32'h12345678, "lat0 rd 0x4");

      write_acc(1'b0, 32'h400, 32'hA5A5A5A5, "wr 0x400");
      read_chk(1'b0, 32'h0, 32'hA5A5A5A5, "wrap rd 0x0");

      write_acc(1'b0, 32'h8, 32'h1, "wr 0x8");
      do_access(1'b0, 1'b1, 1'b1, 32'h8, 32'h2, 1'b1, "rw 0x8", r);
      check_eq("rw 0x8 old data", r, 32'h1);
      read_chk(1'b0, 32'h8, 32'h2, "rd 0x8 after rw");

      do_access(1'b0, 1'b0, 1'b1, 32'hC, 32'h33, 1'b1, "wr 0xC", r);
      check_eq("wr keeps r_data", r, 32'h2);

      exp_q.push_back(32'hDEADBEEF);
      do_access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "dropped rd 0x10", r);
      check_eq("dropped rd r_data", r, exp_q.pop_front());

      do_access(1'b1, 1'b1, 1'b1, 32'h4, 32'h9, 1'b0, "lat0 rw dropped", r);
      check_eq("lat0 rw old data", r, 32'h12345678);
      read_chk(1'b1, 32'h4, 32'h9, "lat0 rd after rw");

      write_acc(1'b0, 32'h13, 32'hFFFFFFFF, "wr 0x13");
`ifdef DMEM_ALIGN_CHECK_EN
      check_eq("misaligned set", 32'(bus2.misaligned), 32'd1);
      read_chk(1'b0, 32'h10, 32'hDEADBEEF, "word 0x10 kept");
      read_chk(1'b0, 32'h11, 32'h0, "misaligned rd 0x11");
      check_eq("misaligned sticky", 32'(bus2.misaligned), 32'd1);
`else
      check_eq("misaligned tied", 32'(bus2.misaligned), 32'd0);
      read_chk(1'b0, 32'h10, 32'hFFFFFFFF, "word 0x10 written");
      read_chk(1'b0, 32'h11, 32'hFFFFFFFF, "rd 0x11 word");
`endif

      write_acc(1'b0, 32'h20, 32'h11111111, "wr 0x20");
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h22222222);
      @(posedge clk); #1;
      check_eq("mid wait state", 32'(dbg2), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst_n = 1'b0;
      #1;
      check_eq("abort state idle", 32'(dbg2), 32'd0);
      check_eq("abort stall", 32'(bus2.stall), 32'd0);
      check_eq("abort resp_valid", 32'(bus2.resp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_eq("abort r_data reset", bus2.r_data, 32'h0);
      check_eq("abort misaligned reset", 32'(bus2.misaligned), 32'd0);
      read_chk(1'b0, 32'h20, 32'h11111111, "word 0x20 kept");

      write_acc(1'b0, 32'h24, 32'h77, "wr 0x24");
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      read_chk(1'b0, 32'h24, 32'h77, "done-reset write kept");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
